// File: rtl/wb_pulse_gen_array.sv
// Wishbone read master that fetches per-channel 32-bit periods, commits
// them atomically and drives NUM_CH glitch-free pulse trains.
module wb_pulse_gen_array #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h400A,
  parameter logic [ADDR_WIDTH-1:0] CH_STRIDE = 16'h0010,
  parameter int MIN_PERIOD = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  update_req,
  input  logic                  GNT,
  input  logic [DATA_WIDTH-1:0] DAT_I,
  input  logic                  ACK_I,
  input  logic                  STALL_I,
  output logic                  CYC_O,
  output logic                  STB_O,
  output logic                  WE_O,
  output logic [ADDR_WIDTH-1:0] ADR_O,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic [NUM_CH-1:0]     pulse_out,
  output logic                  update_done,
  output logic                  fetch_err
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] MIN_P = PW'(MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            word_q, word_d;
  logic            pend_q, pend_d;
  logic            cyc_q, cyc_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [PW-1:0]   shadow_q [NUM_CH];
  logic [PW-1:0]   shadow_d [NUM_CH];
  logic [PW-1:0]   next_q [NUM_CH];
  logic [PW-1:0]   next_d [NUM_CH];
  logic [PW-1:0]   active_q [NUM_CH];
  logic [PW-1:0]   active_d [NUM_CH];
  logic [PW-1:0]   cnt_q [NUM_CH];
  logic [PW-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  logic [ADDR_WIDTH-1:0] adr;

  assign adr = BASE_ADDR
             + ADDR_WIDTH'(ch_q) * CH_STRIDE
             + ADDR_WIDTH'(word_q);

  assign CYC_O       = cyc_q;
  assign STB_O       = (state_q == REQ) & GNT;
  assign ADR_O       = (state_q == REQ) ? adr : '0;
  assign WE_O        = 1'b0;
  assign DAT_O       = '0;
  assign pulse_out   = pulse_q;
  assign update_done = done_q;
  assign fetch_err   = err_q;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    word_d   = word_q;
    pend_d   = pend_q;
    cyc_d    = cyc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    next_d   = next_q;

    if (update_req && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (update_req || pend_q) begin
          cyc_d   = 1'b1;
          pend_d  = 1'b0;
          ch_d    = '0;
          word_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (GNT && !STALL_I) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ACK_I) begin
          if (word_q) begin
            shadow_d[ch_q][DATA_WIDTH-1:0] = DAT_I;
          end else begin
            shadow_d[ch_q][PW-1:DATA_WIDTH] = DAT_I;
          end
          if (!word_q) begin
            word_d  = 1'b1;
            state_d = REQ;
          end else if (ch_q == LAST_CH) begin
            state_d = COMMIT;
          end else begin
            ch_d    = ch_q + 1'b1;
            word_d  = 1'b0;
            state_d = REQ;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COMMIT: begin
        next_d  = shadow_q;
        done_d  = 1'b1;
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new period is only adopted at a wrap or while stopped, so no
  // partial period ever reaches the output.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    pulse_d  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (active_q[c] < MIN_P) begin
        cnt_d[c]    = '0;
        active_d[c] = next_q[c];
      end else begin
        pulse_d[c] = cnt_q[c] < (active_q[c] >> 1);
        if (cnt_q[c] == active_q[c] - 1'b1) begin
          cnt_d[c]    = '0;
          active_d[c] = next_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      word_q   <= 1'b0;
      pend_q   <= 1'b0;
      cyc_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      shadow_q <= '{default: '0};
      next_q   <= '{default: '0};
      active_q <= '{default: '0};
      cnt_q    <= '{default: '0};
      pulse_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      word_q   <= word_d;
      pend_q   <= pend_d;
      cyc_q    <= cyc_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      shadow_q <= shadow_d;
      next_q   <= next_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: tb/tb_wb_pulse_gen_array.sv
// Directed bench for wb_pulse_gen_array with a 2-cycle-ACK RAM slave.
// Table-driven period checks plus hand sequences for bus corner cases.
module tb_wb_pulse_gen_array;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic update_req = 1'b0;
  logic gnt = 1'b1;
  logic ack = 1'b0;
  logic stall = 1'b0;
  logic [DW-1:0] dat_i = '0;
  logic cyc, stb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [NCH-1:0] pulse;
  logic done, err;

  wb_pulse_gen_array #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BASE_ADDR(16'h400A), .CH_STRIDE(16'h0010),
    .MIN_PERIOD(2), .TIMEOUT(TMO)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .update_req(update_req),
    .GNT(gnt), .DAT_I(dat_i), .ACK_I(ack), .STALL_I(stall),
    .CYC_O(cyc), .STB_O(stb), .WE_O(we), .ADR_O(adr),
    .DAT_O(dat_o), .pulse_out(pulse),
    .update_done(done), .fetch_err(err)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [DW-1:0] ram [0:63];
  logic ack_en = 1'b1;
  logic acc_s = 1'b0, d1 = 1'b0;
  logic [AW-1:0] adr_s = '0, d1_adr = '0;
  logic [AW-1:0] adrq [$];

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) - int'(16'h400A);
    if (idx >= 0 && idx < 64) return ram[idx];
    return '0;
  endfunction

  always @(negedge clk) begin
    acc_s = stb & ~stall;
    adr_s = adr;
    if (stb && !stall) adrq.push_back(adr);
  end

  always @(posedge clk) begin
    #1;
    ack    = ack_en & d1;
    dat_i  = d1 ? rd(d1_adr) : '0;
    d1     = acc_s;
    d1_adr = adr_s;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_per(input int c, input logic [31:0] p);
    ram[c*16]     = p[31:16];
    ram[c*16 + 1] = p[15:0];
  endtask

  task automatic pulse_req(output int n);
    update_req = 1'b1;
    n = cyc_n;
    tick();
    update_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        k = cyc_n;
        break;
      end
      tick();
    end
    if (k < 0) chk("done_wait_expired", 0, 1);
  endtask

  task automatic measure(input int c, output int hi, output int lo);
    int g;
    hi = 0;
    lo = 0;
    g  = 0;
    while (pulse[c] !== 1'b0 && g < 64) begin tick(); g++; end
    while (pulse[c] !== 1'b1 && g < 128) begin tick(); g++; end
    while (pulse[c] === 1'b1 && hi < 64) begin hi++; tick(); end
    while (pulse[c] !== 1'b1 && lo < 64) begin lo++; tick(); end
  endtask

  typedef struct {
    int          ch;
    logic [31:0] per;
    int          hi;
    int          lo;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, k1, k2, w, hi, lo, ke;
    logic e, ok, saw_done;

    // hi=0 -> stopped, lo=-1 -> held high for the observed window
    tbl[0] = '{0, 32'd3, 1, 2};
    tbl[1] = '{1, 32'd7, 3, 4};
    tbl[2] = '{0, 32'd1, 0, 0};
    tbl[3] = '{2, 32'd2, 1, 1};
    tbl[4] = '{0, 32'd0, 0, 0};
    tbl[5] = '{3, 32'd9, 4, 5};
    tbl[6] = '{0, 32'hFFFF_FFFF, 1, -1};

    for (int i = 0; i < 64; i++) ram[i] = '0;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_adr", adr, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we_dat", {we, dat_o}, 0);
    repeat (3) tick();

    // First fetch: ch0 P=10, others 0
    set_per(0, 32'd10);
    adrq.delete();
    pulse_req(n);
    chk("cyc_after_req", cyc, 1);
    chk("stb_after_req", stb, 1);
    chk("adr_first", adr, 16'h400A);
    wait_done(60, k1);
    chk("fetch_latency", k1 - n, 26);
    chk("cyc_falls_with_done", cyc, 0);
    chk("addr_count", adrq.size(), 8);
    for (int i = 0; i < 8 && i < adrq.size(); i++)
      chk("addr_seq", adrq[i], 16'h400A + (i / 2) * 16 + (i % 2));
    for (int t = k1 + 1; t <= k1 + 21; t++) begin
      tick();
      e = (t == k1 + 1) ? 1'b0 : (((t - k1 - 2) % 10) < 5);
      chk("p10_wave", pulse[0], e);
      chk("others_low", pulse[3:1], 0);
    end

    // Commit P=4 while ch0 is mid-period at P=10
    set_per(0, 32'd4);
    repeat (3) tick();
    pulse_req(n);
    wait_done(60, k2);
    w = k2;
    while (((w - k1 - 1) % 10) != 9) w++;
    for (int t = k2 + 1; t <= w + 13; t++) begin
      tick();
      if (t <= w + 1) e = (((t - k1 - 2) % 10) < 5);
      else            e = (((t - w - 2) % 4) < 2);
      chk("mid_period_wave", pulse[0], e);
    end

    // GNT withheld for 5 cycles
    gnt = 1'b0;
    pulse_req(n);
    for (int i = 0; i < 5; i++) begin
      chk("nognt_stb", stb, 0);
      chk("nognt_cyc", cyc, 1);
      tick();
    end
    gnt = 1'b1;
    wait_done(80, k);
    chk("nognt_latency", k - n, 31);

    // Stall 3 cycles, one pending request, one dropped request
    repeat (4) tick();
    stall = 1'b1;
    pulse_req(n);
    repeat (3) tick();
    stall = 1'b0;
    repeat (5) tick();
    pulse_req(k);
    repeat (5) tick();
    pulse_req(k);
    wait_done(80, k);
    chk("stall_latency", k - n, 29);
    chk("stall_cyc_fall", cyc, 0);
    tick();
    chk("pending_start", cyc, 1);
    wait_done(80, k2);
    chk("pending_latency", k2 - k, 26);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cyc !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    chk("third_req_dropped", ok, 1);

    // ACK withheld: abort, periods unchanged
    set_per(0, 32'd6);
    ack_en = 1'b0;
    pulse_req(n);
    ke = -1;
    saw_done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (done) saw_done = 1'b1;
      if (err) begin
        ke = cyc_n;
        break;
      end
      tick();
    end
    if (ke < 0) chk("err_wait_expired", 0, 1);
    chk("timeout_latency", ke - n, TMO + 2);
    chk("timeout_cyc", cyc, 0);
    chk("timeout_no_done", saw_done, 0);
    tick();
    chk("err_one_cycle", err, 0);
    ack_en = 1'b1;
    repeat (12) tick();
    measure(0, hi, lo);
    chk("abort_keep_hi", hi, 2);
    chk("abort_keep_lo", lo, 2);

    // Period table
    for (int v = 0; v < 7; v++) begin
      set_per(tbl[v].ch, tbl[v].per);
      pulse_req(n);
      wait_done(60, k);
      chk("tbl_latency", k - n, 26);
      repeat (24) tick();
      if (tbl[v].hi == 0) begin
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
          if (pulse[tbl[v].ch] !== 1'b0) ok = 1'b0;
          tick();
        end
        chk("tbl_stopped_low", ok, 1);
      end else if (tbl[v].lo < 0) begin
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
          if (pulse[tbl[v].ch] !== 1'b1) ok = 1'b0;
          tick();
        end
        chk("tbl_max_period_high", ok, 1);
      end else begin
        measure(tbl[v].ch, hi, lo);
        chk("tbl_high_len", hi, tbl[v].hi);
        chk("tbl_low_len", lo, tbl[v].lo);
      end
    end

    // Reset in the middle of a fetch
    pulse_req(n);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    chk("midrst_cyc", cyc, 0);
    chk("midrst_stb", stb, 0);
    chk("midrst_adr", adr, 0);
    chk("midrst_pulse", pulse, 0);
    chk("midrst_done_err", {done, err}, 0);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse !== '0 || cyc !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    chk("post_rst_quiet", ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
